// File: rtl/player_ctl_multi.sv
// Player ship movement plus a pool of MAX_BULLETS bullets, all stepped once per game tick.
// Optional PLAYER_AUTO_FIRE_EN: a held fire button keeps requesting shots instead of firing once.
module player_ctl_multi #(
  parameter int PLAYER_WIDTH   = 32,
  parameter int PLAYER_HEIGHT  = 32,
  parameter int BULLET_WIDTH   = 4,
  parameter int BULLET_HEIGHT  = 16,
  parameter int MOVEMENT_SPEED = 5,
  parameter int BULLET_SPEED   = 3,
  parameter int MAX_BULLETS    = 4,
  parameter int TICK_CYCLES    = 650000,
  parameter int FIRE_COOLDOWN  = 8,
  parameter int HOR_PIXELS     = 640,
  parameter int VER_PIXELS     = 480
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      button_left,
  input  logic                      button_right,
  input  logic                      button_shoot,
  input  logic [MAX_BULLETS-1:0]    bullet_hit,
  output logic [11:0]               xpos,
  output logic [12*MAX_BULLETS-1:0] bullet_x,
  output logic [12*MAX_BULLETS-1:0] bullet_y,
  output logic [MAX_BULLETS-1:0]    bullet_active,
  output logic                      tick,
  output logic [15:0]               shots_fired
);

  localparam int CW  = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int CDW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

  localparam logic [11:0]    X_RESET  = 12'(HOR_PIXELS / 2);
  localparam logic [11:0]    X_MAX    = 12'(HOR_PIXELS - PLAYER_WIDTH);
  localparam logic [11:0]    MOVE     = 12'(MOVEMENT_SPEED);
  localparam logic [11:0]    BSPD     = 12'(BULLET_SPEED);
  localparam logic [11:0]    SPAWN_DX = 12'(PLAYER_WIDTH / 2 - BULLET_WIDTH / 2);
  localparam logic [11:0]    SPAWN_Y  = 12'(VER_PIXELS - PLAYER_HEIGHT - BULLET_HEIGHT);
  localparam logic [CDW-1:0] CD_LOAD  = CDW'(FIRE_COOLDOWN);

  logic [CW-1:0]          tick_cnt;
  logic                   shoot_prev;
  logic                   fire_pending;
  logic [MAX_BULLETS-1:0] hit_l;
  logic [CDW-1:0]         cooldown;

  logic                   shoot_rise;
  logic                   fire_set;
  logic                   fire_req;
  logic                   slot_free;
  logic                   spawn;
  logic [MAX_BULLETS-1:0] spawn_sel;
  logic [12:0]            xsum;
  logic [11:0]            xpos_next;

  assign shoot_rise = button_shoot & ~shoot_prev;

`ifdef PLAYER_AUTO_FIRE_EN
  assign fire_set = button_shoot;
`else
  assign fire_set = shoot_rise;
`endif

  // Same-cycle request counts so a press landing on the tick cycle is not lost
  assign fire_req = fire_pending | fire_set;

  // Lowest-index free slot in the pre-tick activity map
  always_comb begin
    spawn_sel = '0;
    slot_free = 1'b0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (!slot_free && !bullet_active[i]) begin
        spawn_sel[i] = 1'b1;
        slot_free    = 1'b1;
      end else begin
        spawn_sel[i] = 1'b0;
      end
    end
  end

  assign spawn = fire_req && (cooldown == '0) && slot_free;

  // Ship position with saturation at both screen edges
  always_comb begin
    xsum = {1'b0, xpos} + {1'b0, MOVE};
    if (button_left && !button_right) begin
      xpos_next = (xpos < MOVE) ? 12'd0 : (xpos - MOVE);
    end else if (button_right && !button_left) begin
      xpos_next = (xsum > {1'b0, X_MAX}) ? X_MAX : xsum[11:0];
    end else begin
      xpos_next = xpos;
    end
  end

  // Tick generation, request/hit capture and per-tick game state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      tick          <= 1'b0;
      shoot_prev    <= 1'b0;
      fire_pending  <= 1'b0;
      hit_l         <= '0;
      cooldown      <= '0;
      xpos          <= X_RESET;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_active <= '0;
      shots_fired   <= 16'd0;
    end else begin
      tick_cnt   <= (tick_cnt == CW'(TICK_CYCLES - 1)) ? '0 : tick_cnt + CW'(1);
      tick       <= (tick_cnt == CW'(TICK_CYCLES - 2));
      shoot_prev <= button_shoot;
      if (tick) begin
        fire_pending <= 1'b0;
        hit_l        <= '0;
        xpos         <= xpos_next;
        for (int i = 0; i < MAX_BULLETS; i++) begin
          if (spawn && spawn_sel[i]) begin
            bullet_x[12*i +: 12] <= xpos + SPAWN_DX;
            bullet_y[12*i +: 12] <= SPAWN_Y;
            bullet_active[i]     <= 1'b1;
          end else if (bullet_active[i]) begin
            // Retire before the subtraction could wrap; x/y keep their last values
            if (hit_l[i] || bullet_hit[i] || (bullet_y[12*i +: 12] < BSPD)) begin
              bullet_active[i] <= 1'b0;
            end else begin
              bullet_y[12*i +: 12] <= bullet_y[12*i +: 12] - BSPD;
            end
          end else begin
            bullet_active[i] <= 1'b0;
          end
        end
        if (spawn) begin
          cooldown    <= CD_LOAD;
          shots_fired <= shots_fired + 16'd1;
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CDW'(1);
        end else begin
          cooldown <= cooldown;
        end
      end else begin
        if (fire_set) begin
          fire_pending <= 1'b1;
        end else begin
          fire_pending <= fire_pending;
        end
        hit_l <= hit_l | (bullet_hit & bullet_active);
      end
    end
  end

endmodule

// File: tb/tb_player_ctl_multi.sv
// Self-checking bench for player_ctl_multi (TICK_CYCLES=4, MAX_BULLETS=2, FIRE_COOLDOWN=2, 640x480).
module tb_player_ctl_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        button_left, button_right, button_shoot;
  logic [1:0]  bullet_hit;
  logic [11:0] xpos;
  logic [23:0] bullet_x, bullet_y;
  logic [1:0]  bullet_active;
  logic        tick;
  logic [15:0] shots_fired;

  player_ctl_multi #(
    .MAX_BULLETS  (2),
    .TICK_CYCLES  (4),
    .FIRE_COOLDOWN(2),
    .HOR_PIXELS   (640),
    .VER_PIXELS   (480)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_left  (button_left),
    .button_right (button_right),
    .button_shoot (button_shoot),
    .bullet_hit   (bullet_hit),
    .xpos         (xpos),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_active(bullet_active),
    .tick         (tick),
    .shots_fired  (shots_fired)
  );

  always #5 clk = ~clk;

  // sh: 0 = idle, 1 = one-cycle pulse, 2 = hold high
  typedef struct {
    logic        l;
    logic        r;
    logic [1:0]  sh;
    logic [1:0]  hit;
    logic [11:0] xpos;
    logic [1:0]  act;
    logic [15:0] shots;
    logic [11:0] x0, y0, x1, y1;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb_q[$];
  vec_t tab_a[9];
  vec_t tab_b[2];

  function automatic vec_t mk(int l, int r, int sh, int hit, int xp, int act, int shots,
                              int x0, int y0, int x1, int y1);
    vec_t v;
    v.l = 1'(l); v.r = 1'(r); v.sh = 2'(sh); v.hit = 2'(hit);
    v.xpos = 12'(xp); v.act = 2'(act); v.shots = 16'(shots);
    v.x0 = 12'(x0); v.y0 = 12'(y0); v.x1 = 12'(x1); v.y1 = 12'(y1);
    return v;
  endfunction

  task automatic check_val(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_state(string name, vec_t e);
    n_cmp++;
    if (xpos !== e.xpos || bullet_active !== e.act || shots_fired !== e.shots ||
        bullet_x[11:0] !== e.x0 || bullet_y[11:0] !== e.y0 ||
        bullet_x[23:12] !== e.x1 || bullet_y[23:12] !== e.y1) begin
      n_bad++;
      $display("FAIL %s: got xpos=%0d act=%b shots=%0d x0=%0d y0=%0d x1=%0d y1=%0d expected xpos=%0d act=%b shots=%0d x0=%0d y0=%0d x1=%0d y1=%0d",
               name, xpos, bullet_active, shots_fired, bullet_x[11:0], bullet_y[11:0],
               bullet_x[23:12], bullet_y[23:12], e.xpos, e.act, e.shots, e.x0, e.y0, e.x1, e.y1);
    end
  endtask

  // Returns just after the clock edge on which the game state updates
  task automatic wait_update();
    bit seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL tick_timeout: got no tick expected tick within 12 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_tick(vec_t v, string name);
    vec_t e;
    button_left  = v.l;
    button_right = v.r;
    button_shoot = (v.sh != 2'd0);
    bullet_hit   = v.hit;
    sb_q.push_back(v);
    @(posedge clk); #1;
    if (v.sh != 2'd2) button_shoot = 1'b0;
    bullet_hit = 2'b00;
    wait_update();
    e = sb_q.pop_front();
    check_state(name, e);
  endtask

  initial begin
    int cyc;
    int xp;
    // Spawn/cooldown/slot reuse sequence from a fresh reset
    tab_a[0] = mk(0,0,1,0, 320,2'b01,1, 334,432,   0,  0);
    tab_a[1] = mk(0,0,1,0, 320,2'b01,1, 334,429,   0,  0);
    tab_a[2] = mk(0,0,0,0, 320,2'b01,1, 334,426,   0,  0);
    tab_a[3] = mk(0,0,1,0, 320,2'b11,2, 334,423, 334,432);
    tab_a[4] = mk(0,0,0,0, 320,2'b11,2, 334,420, 334,429);
    tab_a[5] = mk(0,0,0,0, 320,2'b11,2, 334,417, 334,426);
    tab_a[6] = mk(0,0,1,0, 320,2'b11,2, 334,414, 334,423);
    tab_a[7] = mk(0,0,1,1, 320,2'b10,2, 334,414, 334,420);
    tab_a[8] = mk(0,0,1,0, 320,2'b11,3, 334,432, 334,417);
    // After the mid-flight reset: spawn x uses the pre-move ship position
    tab_b[0] = mk(1,0,0,0, 315,2'b00,0,   0,  0,   0,  0);
    tab_b[1] = mk(1,0,1,0, 310,2'b01,1, 329,432,   0,  0);

    rst = 1'b1;
    button_left = 1'b0; button_right = 1'b0; button_shoot = 1'b0; bullet_hit = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset_state", mk(0,0,0,0, 320,0,0, 0,0,0,0));
    check_val("reset_tick", int'(tick), 0);
    @(negedge clk); rst = 1'b0;

    // Tick period and width
    cyc = 0;
    for (int k = 0; k < 12 && !tick; k++) @(negedge clk);
    check_val("tick_first_seen", int'(tick), 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cyc++;
      if (tick) break;
    end
    check_val("tick_period", cyc, 4);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_tick(tab_a[i], $sformatf("tab_a[%0d]", i));

    // Asynchronous reset between clock edges with both slots in flight
    #2 rst = 1'b1;
    #1;
    check_state("reset_midflight", mk(0,0,0,0, 320,0,0, 0,0,0,0));
    check_val("reset_midflight_tick", int'(tick), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wait_update();

    for (int i = 0; i < 2; i++) do_tick(tab_b[i], $sformatf("tab_b[%0d]", i));

    // Bullet climbs to y=0 then retires without wrapping
    for (int k = 1; k <= 145; k++)
      do_tick(mk(0,0,0,0, 310, (k <= 144) ? 1 : 0, 1, 329, (k <= 144) ? 432 - 3*k : 0, 0, 0),
              $sformatf("climb_%0d", k));

    // Right saturation, both-held hold, left saturation
    for (int k = 1; k <= 70; k++) begin
      xp = (310 + 5*k > 608) ? 608 : 310 + 5*k;
      do_tick(mk(0,1,0,0, xp, 0, 1, 329, 0, 0, 0), $sformatf("right_%0d", k));
    end
    for (int k = 1; k <= 3; k++)
      do_tick(mk(1,1,0,0, 608, 0, 1, 329, 0, 0, 0), $sformatf("both_%0d", k));
    for (int k = 1; k <= 130; k++) begin
      xp = (608 - 5*k < 0) ? 0 : 608 - 5*k;
      do_tick(mk(1,0,0,0, xp, 0, 1, 329, 0, 0, 0), $sformatf("left_%0d", k));
    end

    // Fire button held for five ticks
`ifdef PLAYER_AUTO_FIRE_EN
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 432,  0,   0), "hold_1");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 429,  0,   0), "hold_2");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 426,  0,   0), "hold_3");
    do_tick(mk(0,0,2,0, 0, 2'b11, 3, 14, 423, 14, 432), "hold_4");
    do_tick(mk(0,0,2,0, 0, 2'b11, 3, 14, 420, 14, 429), "hold_5");
`else
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 432, 0, 0), "hold_1");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 429, 0, 0), "hold_2");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 426, 0, 0), "hold_3");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 423, 0, 0), "hold_4");
    do_tick(mk(0,0,2,0, 0, 2'b01, 2, 14, 420, 0, 0), "hold_5");
`endif
    button_shoot = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
